// File: rtl/event_encoder_16_4_pkg.sv
// Shared types, sizes and priority pick for the 16-line event encoder.
// Imported by the interface and the encoder top.
package event_encoder_16_4_pkg;

  localparam int N_LINES = 16;
  localparam int CODE_W  = 4;

  localparam logic [CODE_W-1:0] Q_RST = '0;

  // Later hits overwrite earlier ones, so scan order sets the winner.
  function automatic logic [CODE_W-1:0] prio_pick16(
    input logic [N_LINES-1:0] vec,
    input logic               high_first
  );
    logic [CODE_W-1:0] code;
    code = Q_RST;
    for (int i = 0; i < N_LINES; i++) begin
      if (high_first) begin
        if (vec[i])
          code = CODE_W'(i);
      end else begin
        if (vec[N_LINES-1-i])
          code = CODE_W'(N_LINES-1-i);
      end
    end
    return code;
  endfunction

endpackage

// File: rtl/event_encoder_16_4_if.sv
// Valid/ready output channel carrying one 4-bit event code.
// master drives the code, slave accepts it.
interface event_encoder_16_4_if;
  import event_encoder_16_4_pkg::*;

  logic [CODE_W-1:0] Q;
  logic              VALID;
  logic              READY;

  modport master (
    output Q,
    output VALID,
    input  READY
  );

  modport slave (
    input  Q,
    input  VALID,
    output READY
  );

endinterface

// File: rtl/event_encoder_16_4_sync_edge_det.sv
// Multi-flop synchronizer followed by a rising-edge detector.
// Usable for any bundle of asynchronous board inputs.
module sync_edge_det #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] rise
);

  logic [STAGES-1:0][WIDTH-1:0] sync;
  logic [WIDTH-1:0]             s_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      s_d  <= '0;
    end else begin
      sync <= {sync[STAGES-2:0], din};
      s_d  <= sync[STAGES-1];
    end
  end

  // Zero reset means a line high at release yields one edge.
  assign rise = sync[STAGES-1] & ~s_d;

endmodule

// File: rtl/event_encoder_16_4.sv
// Captures rising edges on 16 request lines and drains them
// one per handshake as a 4-bit index code, in fixed priority.
module event_encoder_16_4
  import event_encoder_16_4_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit HIGH_FIRST  = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               EN,
  input  logic [N_LINES-1:0] REQ,
  event_encoder_16_4_if.master evt,
  output logic [N_LINES-1:0] PEND,
  output logic               OVF,
  input  logic               OVF_CLR
);

  logic [N_LINES-1:0] rise;
  logic [N_LINES-1:0] set;
  logic [N_LINES-1:0] clr;
  logic [CODE_W-1:0]  pick;
  logic               load;
  logic               any;

  sync_edge_det #(
    .WIDTH  (N_LINES),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (REQ),
    .rise  (rise)
  );

  assign set  = rise & {N_LINES{EN}};
  assign any  = |PEND;
  assign pick = prio_pick16(PEND, HIGH_FIRST);
  assign load = !evt.VALID || evt.READY;

  always_comb begin
    clr = '0;
    if (load && any)
      clr[pick] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PEND      <= '0;
      OVF       <= 1'b0;
      evt.VALID <= 1'b0;
      evt.Q     <= Q_RST;
    end else begin
      // Set after clear: a fresh edge on the line being loaded survives.
      PEND <= (PEND & ~clr) | set;
      if (|(set & PEND & ~clr))
        OVF <= 1'b1;
      else if (OVF_CLR)
        OVF <= 1'b0;
      if (load) begin
        evt.VALID <= any;
        if (any)
          evt.Q <= pick;
      end
    end
  end

endmodule

// File: tb/tb_event_encoder_16_4.sv
// Bench for event_encoder_16_4: vector table, corner sequences,
// and random traffic against a delay-line/pending-set model.
module tb_event_encoder_16_4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] req;
  logic [15:0] pend;
  logic        ovf;
  logic        ov_clr;

  int n_tests = 0;
  int n_fail  = 0;

  event_encoder_16_4_if oif ();

  event_encoder_16_4 #(
    .SYNC_STAGES (2),
    .HIGH_FIRST  (1'b1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .EN      (en),
    .REQ     (req),
    .evt     (oif),
    .PEND    (pend),
    .OVF     (ovf),
    .OVF_CLR (ov_clr)
  );

  always #5 clk = ~clk;

  // Reference: REQ history plus a set of pending line numbers.
  logic [15:0] hist [3];
  logic [15:0] m_pend;
  logic        m_valid;
  logic [3:0]  m_q;
  logic        m_ovf;

  typedef struct {
    logic [15:0] req;
    logic        ready;
    logic        v;
    logic [3:0]  q;
    logic [15:0] pend;
  } vec_t;

  vec_t tbl [12];

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int ref_pick(logic [15:0] v);
    for (int i = 15; i >= 0; i--)
      if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) hist[i] = '0;
    m_pend  = '0;
    m_valid = 1'b0;
    m_q     = 4'd0;
    m_ovf   = 1'b0;
  endtask

  task automatic model_step();
    logic [15:0] newev;
    int          taken;
    // Two flops of sync, one of delay: compare samples 2 and 3 back.
    newev = en ? (hist[1] & ~hist[2]) : 16'h0;
    taken = -1;
    if (!m_valid || oif.READY) begin
      if (m_pend != 0) begin
        taken   = ref_pick(m_pend);
        m_q     = 4'(taken);
        m_valid = 1'b1;
        m_pend[taken] = 1'b0;
      end else begin
        m_valid = 1'b0;
      end
    end
    if ((newev & m_pend) != 0)
      m_ovf = 1'b1;
    else if (ov_clr)
      m_ovf = 1'b0;
    m_pend = m_pend | newev;
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = req;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("model_valid", 32'(oif.VALID), 32'(m_valid));
    check("model_pend", 32'(pend), 32'(m_pend));
    check("model_ovf", 32'(ovf), 32'(m_ovf));
    if (m_valid)
      check("model_q", 32'(oif.Q), 32'(m_q));
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_line(int i);
    req[i] = 1'b1;
    ticks(3);
    req[i] = 1'b0;
    ticks(2);
  endtask

  task automatic chk_out(string nm, logic v, logic [3:0] q,
                         logic [15:0] p, logic o);
    check({nm, "_valid"}, 32'(oif.VALID), 32'(v));
    if (v) check({nm, "_q"}, 32'(oif.Q), 32'(q));
    check({nm, "_pend"}, 32'(pend), 32'(p));
    check({nm, "_ovf"}, 32'(ovf), 32'(o));
  endtask

  initial begin
    int n7;
    int nv;
    logic [15:0] m;

    tbl[0]  = '{16'h0020, 1'b1, 1'b0, 4'd0,  16'h0000};
    tbl[1]  = '{16'h0020, 1'b1, 1'b0, 4'd0,  16'h0000};
    tbl[2]  = '{16'h0020, 1'b1, 1'b0, 4'd0,  16'h0020};
    tbl[3]  = '{16'h0000, 1'b1, 1'b1, 4'd5,  16'h0000};
    tbl[4]  = '{16'h0000, 1'b1, 1'b0, 4'd0,  16'h0000};
    tbl[5]  = '{16'h4204, 1'b1, 1'b0, 4'd0,  16'h0000};
    tbl[6]  = '{16'h4204, 1'b1, 1'b0, 4'd0,  16'h0000};
    tbl[7]  = '{16'h4204, 1'b1, 1'b0, 4'd0,  16'h4204};
    tbl[8]  = '{16'h4204, 1'b1, 1'b1, 4'd14, 16'h0204};
    tbl[9]  = '{16'h4204, 1'b1, 1'b1, 4'd9,  16'h0004};
    tbl[10] = '{16'h4204, 1'b1, 1'b1, 4'd2,  16'h0000};
    tbl[11] = '{16'h0000, 1'b1, 1'b0, 4'd0,  16'h0000};

    rst_n     = 1'b0;
    en        = 1'b1;
    req       = '0;
    ov_clr    = 1'b0;
    oif.READY = 1'b1;
    model_reset();
    #1;
    chk_out("reset", 1'b0, 4'd0, 16'h0, 1'b0);
    check("reset_q", 32'(oif.Q), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ticks(2);

    for (int k = 0; k < 12; k++) begin
      req       = tbl[k].req;
      oif.READY = tbl[k].ready;
      tick();
      chk_out($sformatf("tbl%0d", k), tbl[k].v, tbl[k].q,
              tbl[k].pend, 1'b0);
    end
    ticks(3);

    // Stall, re-arm while presented, then overflow.
    oif.READY = 1'b0;
    pulse_line(3);
    chk_out("stall_hold", 1'b1, 4'd3, 16'h0000, 1'b0);
    pulse_line(3);
    chk_out("stall_repend", 1'b1, 4'd3, 16'h0008, 1'b0);
    pulse_line(3);
    chk_out("stall_ovf", 1'b1, 4'd3, 16'h0008, 1'b1);
    oif.READY = 1'b1;
    tick();
    chk_out("stall_drain1", 1'b1, 4'd3, 16'h0000, 1'b1);
    tick();
    chk_out("stall_drain2", 1'b0, 4'd0, 16'h0000, 1'b1);

    // Clear coinciding with a new overflow, then clear alone.
    oif.READY = 1'b0;
    pulse_line(4);
    pulse_line(4);
    chk_out("ovf_setup", 1'b1, 4'd4, 16'h0010, 1'b1);
    req[4] = 1'b1;
    ticks(2);
    ov_clr = 1'b1;
    tick();
    ov_clr = 1'b0;
    check("ovf_clr_collide", 32'(ovf), 32'd1);
    req[4] = 1'b0;
    ticks(2);
    ov_clr = 1'b1;
    tick();
    ov_clr = 1'b0;
    check("ovf_clr_alone", 32'(ovf), 32'd0);
    oif.READY = 1'b1;
    tick();
    chk_out("ovf_drain", 1'b1, 4'd4, 16'h0000, 1'b0);
    tick();
    check("ovf_idle", 32'(oif.VALID), 32'd0);

    // Enable gating.
    en  = 1'b0;
    req = 16'h8001;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) req = '0;
      tick();
      chk_out($sformatf("gate%0d", i), 1'b0, 4'd0, 16'h0, 1'b0);
    end
    en        = 1'b1;
    oif.READY = 1'b0;
    req[15]   = 1'b1;
    ticks(3);
    check("en_pend15", 32'(pend), 32'h8000);
    en  = 1'b0;
    req = '0;
    tick();
    chk_out("en_drop", 1'b1, 4'd15, 16'h0, 1'b0);
    oif.READY = 1'b1;
    tick();
    check("en_done", 32'(oif.VALID), 32'd0);
    en = 1'b1;
    ticks(2);

    // Async reset mid-burst with an overflow standing.
    oif.READY = 1'b0;
    req = 16'hF0F0;
    ticks(3);
    req = '0;
    ticks(2);
    req = 16'hF0F0;
    ticks(3);
    req = '0;
    tick();
    check("burst_ovf", 32'(ovf), 32'd1);
    check("burst_valid", 32'(oif.VALID), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 4'd0, 16'h0, 1'b0);
    model_reset();
    req       = 16'h0080;
    oif.READY = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n7 = 0;
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (oif.VALID) begin
        nv++;
        if (oif.Q == 4'd7) n7++;
      end
    end
    check("rst_rel_q7", 32'(n7), 32'd1);
    check("rst_rel_cnt", 32'(nv), 32'd1);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      m = 16'($urandom) & 16'($urandom) & 16'($urandom);
      req       = req ^ m;
      en        = ($urandom_range(0, 7) != 0);
      oif.READY = ($urandom_range(0, 3) != 0);
      ov_clr    = ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
